// File: rtl/add28_operand_queue.sv
`default_nettype none
// ============================================================================
//  Module   : add28_operand_queue
//  Brief    : Circular FIFO of {A,B} 28-bit operand pairs feeding a 28-bit
//             carry-lookahead adder. Valid/ready handshake on both sides;
//             in_ready/out_valid come from registered occupancy only.
//  Options  : SUB_EN - adds the in_sub port; pairs pushed with in_sub=1 store
//             the two's complement of B so the carry-in-less adder
//             produces A-B.
//  Revision : 1.0 - initial release
// ============================================================================
module add28_operand_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [27:0]            in_a,
    input  logic [27:0]            in_b,
`ifdef SUB_EN
    input  logic                   in_sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [27:0]            out_a,
    output logic [27:0]            out_b,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_DATA_W  = 28;
    localparam int c_ENTRY_W = 2 * c_DATA_W;
    localparam int c_AW      = $clog2(DEPTH);
    localparam int c_CW      = c_AW + 1;

    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(DEPTH - 1);

    // Storage is deliberately not reset: stale contents are unreachable once
    // the pointers and occupancy are cleared.
    logic [c_ENTRY_W-1:0] mem_q [DEPTH];

    logic [c_AW-1:0]      wr_ptr_q;
    logic [c_AW-1:0]      wr_ptr_d;
    logic [c_AW-1:0]      rd_ptr_q;
    logic [c_AW-1:0]      rd_ptr_d;
    logic [c_CW-1:0]      count_q;
    logic [c_CW-1:0]      count_d;

    logic                 w_push;
    logic                 w_pop;
    logic [c_DATA_W-1:0]  w_b_store;
    logic [c_ENTRY_W-1:0] w_head;

    // Handshake status is a pure function of registered occupancy, so there is
    // no combinational path from out_ready to in_ready. A full queue refuses a
    // push even when a pop happens in the same cycle.
    assign in_ready  = (count_q < c_FULL);
    assign out_valid = (count_q != '0);

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    assign w_head = mem_q[rd_ptr_q];
    assign count  = count_q;

    // Head pair to the adder; forced to zero when nothing is queued.
    always_comb begin
        out_a = '0;
        out_b = '0;
        if (out_valid) begin
            out_a = w_head[c_ENTRY_W-1:c_DATA_W];
            out_b = w_head[c_DATA_W-1:0];
        end
    end

    // Operand B as written into storage; negated at push time for subtracts
    // so the read side adds no latency.
    always_comb begin
        w_b_store = in_b;
`ifdef SUB_EN
        if (in_sub) begin
            w_b_store = ~in_b + 28'd1;
        end
`endif
    end

    // Next-state for pointers and occupancy; pointers wrap DEPTH-1 -> 0.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == c_LAST) ? '0 : wr_ptr_q + c_AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == c_LAST) ? '0 : rd_ptr_q + c_AW'(1);
        end
        unique case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CW'(1);
            2'b01:   count_d = count_q - c_CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset takes effect without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry write on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {in_a, w_b_store};
        end
    end

endmodule
`default_nettype wire
